// File: rtl/alu_md_ctrl.sv
// EX-stage ALU control decode, combinational ALU and iterative mult/div unit with HI/LO.
// Define ALU_MD_SIGNED_EN to make mult/div signed (one extra sign-correction cycle).
module alu_md_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [1:0]       aluOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W2-1:0]    wk_q;
    logic [WIDTH-1:0] op_q, hi_q, lo_q;

    logic rtype, is_hilo, is_mul, is_div, is_mthi, is_mtlo;
    logic accept, start_md, iterating, last_iter;
    logic [WIDTH-1:0] a_mag, b_mag;

    // HI/LO-class functs are 0100xx and 0110xx
    assign rtype    = (aluOp == 2'b10);
    assign is_hilo  = rtype && ((funct[5:2] == 4'b0110) || (funct[5:2] == 4'b0100));
    assign is_mul   = rtype && (funct[5:1] == 5'b01100);
    assign is_div   = rtype && (funct[5:1] == 5'b01101);
    assign is_mthi  = rtype && (funct == 6'b010001);
    assign is_mtlo  = rtype && (funct == 6'b010011);

    assign stall     = issue_valid & md_busy & is_hilo;
    assign accept    = issue_valid & ~stall;
    assign start_md  = accept & (is_mul | is_div);
    assign iterating = (state_q == S_MUL) || (state_q == S_DIV);
    assign last_iter = iterating && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        result = '0;
        case (aluOp)
            2'b00: result = a + b;
            2'b01: result = a - b;
            2'b11: result = a & b;
            default: begin
                case (funct)
                    6'b100000: result = a + b;
                    6'b100010: result = a - b;
                    6'b100100: result = a & b;
                    6'b100101: result = a | b;
                    6'b100110: result = a ^ b;
                    6'b100111: result = ~(a | b);
                    6'b101010: result = WIDTH'($signed(a) < $signed(b));
                    6'b101011: result = WIDTH'(a < b);
                    6'b010000: result = hi_q;
                    6'b010010: result = lo_q;
                    default:   result = '0;
                endcase
            end
        endcase
    end

    assign zero = (result == '0);

    // One iteration step: shift-add for multiply, restoring step for divide
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [W2-1:0]    step_next;

    always_comb begin
        mul_sum   = {1'b0, wk_q[W2-1:WIDTH]} + (wk_q[0] ? {1'b0, op_q} : '0);
        div_sh    = {wk_q[W2-1:WIDTH], wk_q[WIDTH-1]};
        div_ge    = (div_sh >= {1'b0, op_q});
        div_diff  = div_sh[WIDTH-1:0] - op_q;
        step_next = {mul_sum, wk_q[WIDTH-1:1]};
        if (state_q == S_DIV) begin
            step_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), wk_q[WIDTH-2:0], div_ge};
        end
    end

`ifdef ALU_MD_SIGNED_EN
    logic             neg_q_q, neg_r_q, dz_q, div_q;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    always_comb begin
        prod_fix = neg_q_q ? -wk_q : wk_q;
        quo_fix  = dz_q ? '1 : (neg_q_q ? -wk_q[WIDTH-1:0] : wk_q[WIDTH-1:0]);
        rem_fix  = neg_r_q ? -wk_q[W2-1:WIDTH] : wk_q[W2-1:WIDTH];
    end

    // Sign bookkeeping captured with the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
        end else if (start_md) begin
            neg_q_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r_q <= a[WIDTH-1];
            dz_q    <= is_div && (b == '0);
            div_q   <= is_div;
        end
    end
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_md && is_mul) begin
                    state_d = S_MUL;
                end else if (start_md) begin
                    state_d = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
`ifdef ALU_MD_SIGNED_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        md_busy = 1'b0;
        md_done = 1'b0;
        case (state_q)
            S_MUL, S_DIV, S_FIX: md_busy = 1'b1;
            S_DONE:              md_done = 1'b1;
            default: ;
        endcase
    end

    // Working register: mult {acc, multiplier}, div {remainder, quotient}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            wk_q  <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (start_md) begin
                cnt_q <= '0;
                op_q  <= b_mag;
                wk_q  <= {{WIDTH{1'b0}}, a_mag};
            end else if (iterating) begin
                cnt_q <= cnt_q + CNT_W'(1);
                wk_q  <= step_next;
            end
`ifdef ALU_MD_SIGNED_EN
            if (state_q == S_FIX) begin
                hi_q <= div_q ? rem_fix : prod_fix[W2-1:WIDTH];
                lo_q <= div_q ? quo_fix : prod_fix[WIDTH-1:0];
            end
`else
            if (last_iter) begin
                hi_q <= step_next[W2-1:WIDTH];
                lo_q <= step_next[WIDTH-1:0];
            end
`endif
            if (accept && is_mthi) hi_q <= a;
            if (accept && is_mtlo) lo_q <= a;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Directed self-checking bench for alu_md_ctrl (default build, WIDTH=32).
module tb_alu_md_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [1:0]  aluOp;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic [31:0] result, hi, lo;
    logic        zero, stall, md_busy, md_done;

    int errors = 0;
    int checks = 0;

    alu_md_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .aluOp(aluOp),
        .funct(funct), .a(a), .b(b), .result(result), .zero(zero),
        .stall(stall), .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv);
        issue_valid = v;
        aluOp       = op;
        funct       = fn;
        a           = av;
        b           = bv;
    endtask

    task automatic alu(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_res, input logic exp_zero);
        @(negedge clk);
        drive(1'b1, op, fn, av, bv);
        #1;
        check(tag, result, exp_res);
        check({tag, "_zero"}, zero, exp_zero);
        check({tag, "_stall"}, stall, 1'b0);
    endtask

    // Issue a mult/div, count busy cycles; returns positioned at the md_done sample
    task automatic run_md(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv,
                          output int busy_n, output int done_at);
        busy_n  = 0;
        done_at = 0;
        @(negedge clk);
        drive(1'b1, 2'b10, fn, av, bv);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        for (int i = 1; i <= 100; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            if (md_done) begin
                done_at = i;
                break;
            end
            if (md_busy) busy_n++;
        end
    endtask

    int busy_n, done_at, stall_n;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", md_busy, 1'b0);
        check("rst_done", md_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        alu("sub_r",    2'b10, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        alu("slt_pos",  2'b10, 6'b101010, 32'd5, 32'd7, 32'd1, 1'b0);
        alu("sltu_pos", 2'b10, 6'b101011, 32'd5, 32'd7, 32'd1, 1'b0);
        alu("slt_neg",  2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        alu("sltu_neg", 2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        alu("and_op",   2'b11, 6'b000000, 32'hF0, 32'h3C, 32'h30, 1'b0);
        alu("add_wrap", 2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        alu("sub_op",   2'b01, 6'b000000, 32'd10, 32'd3, 32'd7, 1'b0);
        alu("or_r",     2'b10, 6'b100101, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        alu("xor_r",    2'b10, 6'b100110, 32'hFF, 32'h0F, 32'hF0, 1'b0);
        alu("nor_r",    2'b10, 6'b100111, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
        alu("add_r",    2'b10, 6'b100000, 32'd2, 32'd3, 32'd5, 1'b0);
        alu("bad_fn",   2'b10, 6'b111111, 32'd9, 32'd9, 32'd0, 1'b1);
        alu("mfhi_rst", 2'b10, 6'b010000, 32'd0, 32'd0, 32'd0, 1'b1);

        run_md(6'b011001, 32'hFFFF_FFFF, 32'd2, busy_n, done_at);
        check("multu_busy_cycles", 64'(busy_n), 64'd32);
        check("multu_done_at", 64'(done_at), 64'd33);
        check("multu_hi", hi, 32'd1);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0);
        #1;
        check("mflo_in_done", result, 32'hFFFF_FFFE);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        #1;
        check("done_pulse_low", md_done, 1'b0);
        check("busy_after_done", md_busy, 1'b0);

        run_md(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_n, done_at);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'd1);

        run_md(6'b011011, 32'd100, 32'd7, busy_n, done_at);
        check("divu_done_at", 64'(done_at), 64'd33);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_md(6'b011011, 32'd100, 32'd0, busy_n, done_at);
        check("divz_busy_cycles", 64'(busy_n), 64'd32);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'd100);

        // mflo held from 3 cycles after a multu until DONE, with one add slipped in
        @(negedge clk);
        drive(1'b1, 2'b10, 6'b011001, 32'd3, 32'd4);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        @(negedge clk);
        stall_n = 0;
        done_at = 0;
        for (int i = 3; i <= 100; i++) begin
            @(negedge clk);
            if (i == 10) drive(1'b1, 2'b00, 6'd0, 32'd1, 32'd2);
            else         drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0);
            #1;
            if (i == 10) begin
                check("add_mid_stall", stall, 1'b0);
                check("add_mid_res", result, 32'd3);
            end else if (md_done) begin
                done_at = i;
                break;
            end else if (stall) begin
                stall_n++;
            end
        end
        check("mflo_stall_cycles", 64'(stall_n), 64'd29);
        check("mflo_done_at", 64'(done_at), 64'd33);
        check("mflo_done_stall", stall, 1'b0);
        check("mflo_done_res", result, 32'd12);

        alu("mthi_res", 2'b10, 6'b010001, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b1);
        alu("mtlo_res", 2'b10, 6'b010011, 32'h1234_5678, 32'd0, 32'd0, 1'b1);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        #1;
        check("mtlo_lo", lo, 32'h1234_5678);

        // Asynchronous reset in the middle of a divu
        @(negedge clk);
        drive(1'b1, 2'b10, 6'b011011, 32'd100, 32'd7);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        #1;
        check("div_mid_busy", md_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", md_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0);
        #1;
        check("post_rst_stall", stall, 1'b0);
        check("post_rst_mflo", result, 32'd0);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        #1;
        check("post_rst_idle", md_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_md_ctrl.md
Name: alu_md_ctrl

Overview:
- Parametrised successor to the single-cycle ALU control decode.
- Merges aluOp/funct decode, a combinational ALU datapath and an iterative multiply/divide unit with HI/LO registers.
- Sits in the EX stage of the MIPS core. Raises a stall while the multi-cycle unit is busy and a dependent instruction is issued.

Parameters:
- WIDTH, 32, datapath width in bits (even, >= 8); sets operand, result, HI and LO widths.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- issue_valid  input  1  an instruction is presented this cycle
- aluOp  input  2  00 add, 01 sub, 10 R-type (use funct), 11 and
- funct  input  6  R-type function field
- a  input  WIDTH  operand rs
- b  input  WIDTH  operand rt
- result  output  WIDTH  combinational ALU / mfhi / mflo result
- zero  output  1  result == 0
- stall  output  1  hold the pipeline this cycle
- md_busy  output  1  multiply/divide iteration in progress
- md_done  output  1  one-cycle pulse when HI/LO are updated by mult/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - hi=0, lo=0, md_busy=0, md_done=0, counter=0, FSM=IDLE.
  - An operation in flight is aborted and its result is discarded.
- Combinational decode, 0-cycle latency:
  - aluOp 00 -> a+b; 01 -> a-b; 11 -> a&b.
  - aluOp 10, funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed, result 1 or 0), 101011 sltu.
  - aluOp 10, funct 010000 mfhi -> hi; 010010 mflo -> lo.
  - Any other funct -> result 0. Add/sub wrap modulo 2^WIDTH; there is no overflow trap.
- HI/LO-class ops: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011, mfhi, mflo.
- stall = issue_valid & md_busy & (instruction is HI/LO-class). An instruction is accepted only when issue_valid=1 and stall=0.
- mthi/mtlo: an accepted instruction writes a into hi or lo at the next edge; result=0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL or DIV on an accepted mult/div. Operands are latched at that edge; md_busy=1 from the next cycle.
  - MUL: shift-add, one bit per cycle, WIDTH cycles. Full 2*WIDTH product: hi = upper half, lo = lower half.
  - DIV: restoring division, one bit per cycle, WIDTH cycles. lo = quotient, hi = remainder.
  - DONE: hi/lo are written at the edge entering DONE. In DONE: md_done=1, md_busy=0. Next state is IDLE.
  - A new mult/div accepted in DONE starts normally (back-to-back allowed).
  - Total latency: accept edge to DONE = WIDTH+1 cycles.
- Divide by zero: still takes WIDTH cycles; lo = all ones, hi = dividend (a). No exception is raised.
- Non-HI/LO instructions never stall, including while md_busy=1.
- mfhi/mflo during DONE return the freshly written hi/lo.

Optional Feature:
- Macro ALU_MD_SIGNED_EN.
- Defined:
  - mult and div are signed. Operands are converted to magnitudes; results are sign-corrected in one extra cycle before DONE, giving latency WIDTH+2.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / -1 gives lo=MIN, hi=0.
  - Signed divide by zero: lo = all ones, hi = a.
- Not defined:
  - mult/div execute exactly as multu/divu with latency WIDTH+1.
  - slt is unaffected either way.

Test Plan:
- Reset then ALU ops: aluOp=10, funct=100010, a=5, b=7 -> result=0xFFFFFFFE, zero=0. funct=101010, same operands -> result=1. aluOp=11, a=0xF0, b=0x3C -> result=0x30.
- multu a=0xFFFFFFFF, b=2 -> md_busy high 32 cycles, md_done pulse at cycle 33, hi=1, lo=0xFFFFFFFE.
- divu a=100, b=7 -> lo=14, hi=2. divu with b=0 -> lo=0xFFFFFFFF, hi=100.
- mflo issued 3 cycles after multu -> stall=1 until the DONE cycle, then result=lo. An add issued mid-operation -> stall=0.
- Assert rst_n low at cycle 10 of a divu -> hi=lo=0, md_busy=0 immediately. The next mflo returns 0 without stall.
- With ALU_MD_SIGNED_EN: mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. div a=-7, b=2 -> lo=-3, hi=-1, latency 34.
